// File: rtl/pacman_input_ctrl_pkg.sv
// Shared constants and types for the pacman input front-end:
// PS/2 scan codes, joystick bit positions and the coin FSM states.
package pacman_input_pkg;

  localparam logic [7:0] KC_UP     = 8'h75;
  localparam logic [7:0] KC_DOWN   = 8'h72;
  localparam logic [7:0] KC_LEFT   = 8'h6B;
  localparam logic [7:0] KC_RIGHT  = 8'h74;
  localparam logic [7:0] KC_SPACE  = 8'h29;
  localparam logic [7:0] KC_CTRL   = 8'h14;
  localparam logic [7:0] KC_F1     = 8'h05;
  localparam logic [7:0] KC_F2     = 8'h06;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;

  localparam int COIN_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COIN = 2'd1,
    GAP  = 2'd2
  } coin_state_t;

endpackage

// File: rtl/pacman_input_ctrl_if.sv
// Bundle of the raw controls coming from hps_io/core and the active-low
// in0/in1 words going back into the pacman core.
interface pacman_input_if;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic        vblank;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        coin_busy;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate, vblank,
    input  in0, in1, coin_busy
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate, vblank,
    output in0, in1, coin_busy
  );
endinterface

// File: rtl/pacman_input_ctrl_coin_pulse.sv
// Turns start-button rising edges into a coin pulse lasting a fixed number
// of frames, followed by a fixed gap, with a one-deep pending request.
module pacman_coin_pulse
  import pacman_input_pkg::*;
#(
  parameter int COIN_ON_FRAMES  = 4,
  parameter int COIN_GAP_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic vblank,
  input  logic req,
  output logic coin,
  output logic busy
);

  localparam logic [COIN_CNT_W-1:0] ON_LAST  = COIN_CNT_W'(COIN_ON_FRAMES);
  localparam logic [COIN_CNT_W-1:0] GAP_LAST = COIN_CNT_W'(COIN_GAP_FRAMES);

  coin_state_t           state_q, state_d;
  logic [COIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic                  vblank_q;
  logic                  req_q;

  logic                  tick;
  logic                  req_edge;
  logic [COIN_CNT_W-1:0] cnt_inc;

  assign tick     = vblank & ~vblank_q;
  assign req_edge = req & ~req_q;
  assign cnt_inc  = cnt_q + COIN_CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      vblank_q  <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      vblank_q  <= vblank;
      req_q     <= req;
    end
  end

  // A request edge landing on the GAP-exit tick is honoured as if it were pending.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    coin      = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_edge) begin
          state_d = COIN;
          cnt_d   = '0;
        end
      end
      COIN: begin
        coin = 1'b1;
        busy = 1'b1;
        if (req_edge) pending_d = 1'b1;
        if (tick) begin
          if (cnt_inc == ON_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      GAP: begin
        busy = 1'b1;
        if (req_edge) pending_d = 1'b1;
        if (tick) begin
          if (cnt_inc == GAP_LAST) begin
            cnt_d = '0;
            if (pending_q || req_edge) begin
              state_d   = COIN;
              pending_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pacman_input_ctrl.sv
// PS/2 key decode, joystick merge and orientation remap feeding the pacman
// core's active-low in0/in1 words, plus a frame-timed coin pulse.
module pacman_input_ctrl
  import pacman_input_pkg::*;
#(
  parameter int COIN_ON_FRAMES  = 4,
  parameter int COIN_GAP_FRAMES = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  pacman_input_if.slave  io
);

  logic       primed_q;
  logic       toggle_q;
  logic       key_up_q, key_down_q, key_left_q, key_right_q;
  logic       key_fire_q, key_start1_q, key_start2_q;
  logic [7:0] in0_q, in1_q;

  logic       key_event;
  logic       pressed;
  logic       ext;
  logic [8:0] code;

  logic [6:0] joy;
  logic       up, down, left, right, fire, start1, start2, req;
  logic       coin, busy;

  // The first edge after reset only learns the toggle level, so a stale bit 64 is not an event.
  assign key_event = primed_q && (io.ps2_key[64] != toggle_q);

  always_comb begin
    pressed = (io.ps2_key[15:8] != PS2_BREAK);
    ext     = pressed ? (io.ps2_key[15:8] == PS2_EXT) : (io.ps2_key[23:16] == PS2_EXT);
    code    = (io.ps2_key[63:24] != '0) ? 9'h000 : {ext, io.ps2_key[7:0]};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      primed_q     <= 1'b0;
      toggle_q     <= 1'b0;
      key_up_q     <= 1'b0;
      key_down_q   <= 1'b0;
      key_left_q   <= 1'b0;
      key_right_q  <= 1'b0;
      key_fire_q   <= 1'b0;
      key_start1_q <= 1'b0;
      key_start2_q <= 1'b0;
    end else begin
      primed_q <= 1'b1;
      toggle_q <= io.ps2_key[64];
      if (key_event) begin
        case (code)
          {1'b0, KC_UP},    {1'b1, KC_UP}:    key_up_q    <= pressed;
          {1'b0, KC_DOWN},  {1'b1, KC_DOWN}:  key_down_q  <= pressed;
          {1'b0, KC_LEFT},  {1'b1, KC_LEFT}:  key_left_q  <= pressed;
          {1'b0, KC_RIGHT}, {1'b1, KC_RIGHT}: key_right_q <= pressed;
          {1'b0, KC_SPACE}, {1'b0, KC_CTRL}:  key_fire_q  <= pressed;
          {1'b0, KC_F1}:                      key_start1_q <= pressed;
          {1'b0, KC_F2}:                      key_start2_q <= pressed;
          default: ;
        endcase
      end
    end
  end

  // Horz orientation rotates the stick a quarter turn: up<-left, down<-right, left<-down, right<-up.
  always_comb begin
    joy = io.joystick_0[6:0] | io.joystick_1[6:0];
    if (io.rotate) begin
      up    = key_left_q  | joy[JOY_LEFT];
      down  = key_right_q | joy[JOY_RIGHT];
      left  = key_down_q  | joy[JOY_DOWN];
      right = key_up_q    | joy[JOY_UP];
    end else begin
      up    = key_up_q    | joy[JOY_UP];
      down  = key_down_q  | joy[JOY_DOWN];
      left  = key_left_q  | joy[JOY_LEFT];
      right = key_right_q | joy[JOY_RIGHT];
    end
    fire   = key_fire_q   | joy[JOY_FIRE];
    start1 = key_start1_q | joy[JOY_START1];
    start2 = key_start2_q | joy[JOY_START2];
    req    = start1 | start2;
  end

  pacman_coin_pulse #(
    .COIN_ON_FRAMES  (COIN_ON_FRAMES),
    .COIN_GAP_FRAMES (COIN_GAP_FRAMES)
  ) u_coin_pulse (
    .clk    (CLK),
    .rst    (RESET),
    .vblank (io.vblank),
    .req    (req),
    .coin   (coin),
    .busy   (busy)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in0_q <= 8'hFF;
      in1_q <= 8'hFF;
    end else begin
      in0_q <= ~{2'b00, coin, fire, down, right, left, up};
      in1_q <= ~{1'b0, start2, start1, 5'b00000};
    end
  end

  assign io.in0       = in0_q;
  assign io.in1       = in1_q;
  assign io.coin_busy = busy;

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Scoreboard bench for pacman_input_ctrl: a frame-level reference model
// predicts in0/in1/coin_busy every cycle and a monitor compares them.
module tb_pacman_input_ctrl;

  localparam int ON_FRAMES  = 4;
  localparam int GAP_FRAMES = 4;

  typedef struct {
    logic [7:0] in0;
    logic [7:0] in1;
    logic       busy;
  } expect_t;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  expect_t exp_q[$];

  pacman_input_if io();

  pacman_input_ctrl #(
    .COIN_ON_FRAMES  (ON_FRAMES),
    .COIN_GAP_FRAMES (GAP_FRAMES)
  ) dut (
    .CLK   (clk_sys),
    .RESET (rst),
    .io    (io)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model state: held functions, coin/gap frames still to run, one pending coin.
  bit      m_primed;
  bit      m_tog;
  bit      m_held[7];
  bit      m_prev_req;
  bit      m_prev_vb;
  bit      m_pending;
  int      m_coin_left;
  int      m_gap_left;
  logic [15:0] m_joy;
  logic    m_u, m_d, m_l, m_r, m_ru, m_rd, m_rl, m_rr, m_fire, m_s1, m_s2, m_req, m_tick, m_edge;
  logic    m_pressed, m_ext;
  logic [8:0] m_code;
  int      m_fn;
  expect_t m_exp;

  // Function index: 0 up, 1 down, 2 left, 3 right, 4 fire, 5 start1, 6 start2.
  function automatic int keyFunction(logic [8:0] code);
    if (code[7:0] == 8'h75) return 0;
    if (code[7:0] == 8'h72) return 1;
    if (code[7:0] == 8'h6B) return 2;
    if (code[7:0] == 8'h74) return 3;
    if (code == 9'h029 || code == 9'h014) return 4;
    if (code == 9'h005) return 5;
    if (code == 9'h006) return 6;
    return -1;
  endfunction

  always @(posedge clk_sys) begin
    if (rst) begin
      m_primed = 0; m_tog = 0; m_prev_req = 0; m_prev_vb = 0; m_pending = 0;
      m_coin_left = 0; m_gap_left = 0;
      for (int i = 0; i < 7; i++) m_held[i] = 0;
      exp_q.delete();
    end else begin
      m_joy = io.joystick_0 | io.joystick_1;
      m_ru = m_held[0] | m_joy[3];
      m_rd = m_held[1] | m_joy[2];
      m_rl = m_held[2] | m_joy[1];
      m_rr = m_held[3] | m_joy[0];
      if (io.rotate) begin
        m_u = m_rl; m_d = m_rr; m_l = m_rd; m_r = m_ru;
      end else begin
        m_u = m_ru; m_d = m_rd; m_l = m_rl; m_r = m_rr;
      end
      m_fire = m_held[4] | m_joy[4];
      m_s1   = m_held[5] | m_joy[5];
      m_s2   = m_held[6] | m_joy[6];
      m_exp.in0 = ~{2'b00, (m_coin_left > 0), m_fire, m_d, m_r, m_l, m_u};
      m_exp.in1 = ~{1'b0, m_s2, m_s1, 5'b00000};

      m_req  = m_s1 | m_s2;
      m_edge = m_req && !m_prev_req;
      m_tick = io.vblank && !m_prev_vb;
      m_prev_req = m_req;
      m_prev_vb  = io.vblank;
      if (m_coin_left > 0) begin
        if (m_edge) m_pending = 1;
        if (m_tick) begin
          m_coin_left--;
          if (m_coin_left == 0) m_gap_left = GAP_FRAMES;
        end
      end else if (m_gap_left > 0) begin
        if (m_edge) m_pending = 1;
        if (m_tick) begin
          m_gap_left--;
          if (m_gap_left == 0 && m_pending) begin
            m_coin_left = ON_FRAMES;
            m_pending   = 0;
          end
        end
      end else if (m_edge) begin
        m_coin_left = ON_FRAMES;
      end
      m_exp.busy = (m_coin_left > 0) || (m_gap_left > 0);

      if (!m_primed) begin
        m_primed = 1;
      end else if (io.ps2_key[64] != m_tog) begin
        m_pressed = (io.ps2_key[15:8] != 8'hF0);
        m_ext = m_pressed ? (io.ps2_key[15:8] == 8'hE0) : (io.ps2_key[23:16] == 8'hE0);
        m_code = {m_ext, io.ps2_key[7:0]};
        if (io.ps2_key[63:24] == 40'h0) begin
          m_fn = keyFunction(m_code);
          if (m_fn >= 0) m_held[m_fn] = m_pressed;
        end
      end
      m_tog = io.ps2_key[64];
      exp_q.push_back(m_exp);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (!rst && exp_q.size() > 0) begin
      expect_t e;
      e = exp_q.pop_front();
      checkOutput("in0", io.in0, e.in0);
      checkOutput("in1", io.in1, e.in1);
      checkOutput("coin_busy", {7'b0, io.coin_busy}, {7'b0, e.busy});
    end
  end

  task automatic nextSlot();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) nextSlot();
  endtask

  task automatic applyStimulus(input logic [15:0] j0, input logic [15:0] j1,
                               input logic rot, input logic vb);
    nextSlot();
    io.joystick_0 = j0;
    io.joystick_1 = j1;
    io.rotate     = rot;
    io.vblank     = vb;
  endtask

  task automatic sendKey(input logic [63:0] payload);
    nextSlot();
    io.ps2_key = {~io.ps2_key[64], payload};
  endtask

  task automatic vblankPulses(input int n);
    repeat (n) begin
      nextSlot(); io.vblank = 1'b1;
      idle(2);    io.vblank = 1'b0;
      idle(3);
    end
  endtask

  task automatic startPulse(input logic [15:0] bits);
    applyStimulus(bits, 16'h0, 1'b0, io.vblank);
    applyStimulus(16'h0, 16'h0, 1'b0, io.vblank);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, time %0t, required under 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  codes[10];
    logic [7:0]  c;
    logic [23:0] scan;
    logic [39:0] hi;
    bit          rel, ext;

    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06, 8'h1C, 8'h00};
    io.ps2_key = {1'b1, 64'h0};
    io.joystick_0 = '0; io.joystick_1 = '0; io.rotate = 1'b0; io.vblank = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_sys);
    nextSlot(); rst = 1'b0;
    idle(5);

    sendKey(64'h0075); idle(3);
    sendKey(64'hF075); idle(3);

    applyStimulus(16'h0, 16'h0008, 1'b1, 1'b0); idle(3);
    applyStimulus(16'h0, 16'h0008, 1'b0, 1'b0); idle(3);
    applyStimulus(16'h0, 16'h0000, 1'b0, 1'b0); idle(2);

    sendKey(64'h0005); idle(2);
    sendKey(64'hF005);
    vblankPulses(10);

    // Second edge during COIN queues one pulse; a third edge in the window is dropped.
    startPulse(16'h0020); vblankPulses(1);
    startPulse(16'h0020); vblankPulses(1);
    startPulse(16'h0040); vblankPulses(12);

    // Request edge coinciding with the GAP-exit tick.
    startPulse(16'h0040); vblankPulses(7);
    applyStimulus(16'h0040, 16'h0, 1'b0, 1'b1); idle(2);
    applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0); idle(3);
    vblankPulses(10);

    // Tick and request edge together while idle.
    applyStimulus(16'h0020, 16'h0, 1'b0, 1'b1); idle(2);
    applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0); idle(3);
    vblankPulses(10);

    // Reset mid-pulse.
    startPulse(16'h0020); vblankPulses(2);
    @(posedge clk_sys); #2;
    rst = 1'b1;
    #1;
    checkOutput("async_in0", io.in0, 8'hFF);
    checkOutput("async_busy", {7'b0, io.coin_busy}, 8'h00);
    idle(2); rst = 1'b0;
    idle(2); vblankPulses(10);

    sendKey({40'h1, 24'h000075}); idle(3);
    sendKey(64'h0075); idle(2);
    sendKey({40'h1, 24'h00F075}); idle(2);
    sendKey(64'hE075); idle(2);
    sendKey(64'hE0F075); idle(2);
    sendKey(64'h0029); sendKey(64'h0014); sendKey(64'hF029); idle(2);
    sendKey(64'hF014); idle(2);

    repeat (800) begin
      nextSlot();
      if ($urandom_range(0, 3) == 0) io.vblank = ~io.vblank;
      if ($urandom_range(0, 9) == 0) io.joystick_0 = 16'($urandom_range(0, 127) & $urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) io.joystick_1 = 16'($urandom_range(0, 127) & $urandom_range(0, 127));
      if ($urandom_range(0, 29) == 0) io.rotate = ~io.rotate;
      if ($urandom_range(0, 5) == 0) begin
        c   = codes[$urandom_range(0, 9)];
        rel = ($urandom_range(0, 1) == 1);
        ext = ($urandom_range(0, 3) == 0);
        if (rel) scan = ext ? {8'hE0, 8'hF0, c} : {8'h00, 8'hF0, c};
        else     scan = ext ? {8'h00, 8'hE0, c} : {16'h0000, c};
        hi = ($urandom_range(0, 7) == 0) ? 40'($urandom_range(1, 255)) : 40'h0;
        io.ps2_key = {~io.ps2_key[64], hi, scan};
      end
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
